adc_link_trainer: RTL and testbench



---
 rtl/adc_pkg.sv | 26 ++
 rtl/adc_link_trainer.sv | 121 ++++++++++++
 tb/tb_adc_link_trainer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC LVDS link-training sequencer.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SETTLE,
        CHECK,
        SLIP,
        VERIFY,
        LOCKED,
        FAIL
    } trainer_state_e;

    localparam logic [7:0] FRAME_PATTERN_DEFAULT = 8'hF0;

    localparam int MAX_SLIPS_LIMIT = 15;
    localparam int SLIP_CNT_W      = $clog2(MAX_SLIPS_LIMIT + 1);
    localparam int RETRAIN_CNT_W   = 8;

    // Width of a counter that runs 0 .. max_count-1.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/adc_link_trainer.sv
// Link-training sequencer: resets the ISERDES, bitslips until the frame-clock
// word matches, declares lock, and retrains when alignment is lost.
module adc_link_trainer
    import adc_pkg::*;
#(
    parameter logic [7:0] FRAME_PATTERN = FRAME_PATTERN_DEFAULT,
    parameter int         RST_CYCLES    = 8,
    parameter int         SETTLE_CYCLES = 3,
    parameter int         MAX_SLIPS     = 8,
    parameter int         LOCK_COUNT    = 16,
    parameter int         ERR_LIMIT     = 4
) (
    input  logic                     CLKDIV,
    input  logic                     asyncrst_n,
    input  logic                     adc_en,
    input  logic                     train_req,
    input  logic [7:0]               frm_data,
    output logic                     serdes_rst,
    output logic                     serdes_ce,
    output logic                     bitslip,
    output logic                     aligned,
    output logic                     train_fail,
    output logic [SLIP_CNT_W-1:0]    slip_cnt,
    output logic [RETRAIN_CNT_W-1:0] retrain_cnt
);

    localparam int MAX_AB = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CD = (LOCK_COUNT > ERR_LIMIT) ? LOCK_COUNT : ERR_LIMIT;
    localparam int CNT_W  = cnt_width((MAX_AB > MAX_CD) ? MAX_AB : MAX_CD);

    localparam logic [CNT_W-1:0]      RST_LAST      = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      LOCK_LAST     = CNT_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0]      ERR_LAST      = CNT_W'(ERR_LIMIT - 1);
    localparam logic [SLIP_CNT_W-1:0] SLIP_BUDGET   = SLIP_CNT_W'(MAX_SLIPS);
    localparam bit                    LOCK_ON_FIRST = (LOCK_COUNT <= 1);

    trainer_state_e   state, state_nxt, miss_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             match;
    logic             retrain;
    logic             rst_entry;

    // cnt is a per-state timer: reset cycles, settle cycles, matches, or errors.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retrain   = 1'b0;
        match     = (frm_data == FRAME_PATTERN);
        miss_nxt  = (slip_cnt < SLIP_BUDGET) ? SLIP : FAIL;

        if (!adc_en) begin
            state_nxt = IDLE;
        end else if (train_req && state != IDLE && state != RST) begin
            state_nxt = RST;
        end else begin
            case (state)
                IDLE:   state_nxt = RST;
                RST:    if (cnt == RST_LAST) state_nxt = SETTLE;
                        else cnt_nxt = cnt + 1'b1;
                SETTLE: if (cnt == SETTLE_LAST) state_nxt = CHECK;
                        else cnt_nxt = cnt + 1'b1;
                CHECK:  if (match) state_nxt = LOCK_ON_FIRST ? LOCKED : VERIFY;
                        else state_nxt = miss_nxt;
                SLIP:   state_nxt = SETTLE;
                VERIFY: begin
                    if (!match)                state_nxt = miss_nxt;
                    else if (cnt == LOCK_LAST) state_nxt = LOCKED;
                    else                       cnt_nxt = cnt + 1'b1;
                end
                LOCKED: begin
                    if (match) begin
                        cnt_nxt = '0;
                    end else if (cnt == ERR_LAST) begin
                        state_nxt = RST;
                        retrain   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                FAIL:    state_nxt = FAIL;
                default: state_nxt = IDLE;
            endcase
        end

        // The CHECK cycle already counted as the first match.
        if (state_nxt != state) cnt_nxt = (state_nxt == VERIFY) ? CNT_W'(1) : '0;
    end

    assign rst_entry = (state_nxt == RST) && (state != RST);

    always_ff @(posedge CLKDIV or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            serdes_rst  <= 1'b1;
            serdes_ce   <= 1'b0;
            bitslip     <= 1'b0;
            aligned     <= 1'b0;
            train_fail  <= 1'b0;
            slip_cnt    <= '0;
            retrain_cnt <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            serdes_rst <= (state_nxt == IDLE) || (state_nxt == RST);
            serdes_ce  <= !((state_nxt == IDLE) || (state_nxt == RST));
            bitslip    <= (state_nxt == SLIP);
            aligned    <= (state == LOCKED) && (state_nxt == LOCKED);
            if (rst_entry) begin
                slip_cnt   <= '0;
                train_fail <= 1'b0;
            end else begin
                if (state_nxt == SLIP) slip_cnt <= slip_cnt + 1'b1;
                if (state_nxt == FAIL) train_fail <= 1'b1;
            end
            if (retrain && retrain_cnt != '1) retrain_cnt <= retrain_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_link_trainer.sv
// Self-checking bench for adc_link_trainer: a behavioural model checked every
// cycle plus directed scenarios with hand-computed expectations.
module tb_adc_link_trainer;

    localparam logic [7:0] PAT   = 8'hF0;
    localparam int         RSTC  = 8;
    localparam int         SETC  = 3;
    localparam int         MAXS  = 8;
    localparam int         LOCKC = 16;
    localparam int         ERRL  = 4;

    logic       CLKDIV     = 1'b0;
    logic       asyncrst_n = 1'b0;
    logic       adc_en     = 1'b0;
    logic       train_req  = 1'b0;
    logic [7:0] frm_data;
    logic [7:0] frm_fixed  = 8'hF0;
    logic [7:0] rot_word   = 8'h1E;
    logic       use_rot    = 1'b0;

    logic       serdes_rst, serdes_ce, bitslip, aligned, train_fail;
    logic [3:0] slip_cnt;
    logic [7:0] retrain_cnt;

    assign frm_data = use_rot ? rot_word : frm_fixed;

    always #5 CLKDIV = ~CLKDIV;

    adc_link_trainer #(
        .FRAME_PATTERN(PAT),
        .RST_CYCLES   (RSTC),
        .SETTLE_CYCLES(SETC),
        .MAX_SLIPS    (MAXS),
        .LOCK_COUNT   (LOCKC),
        .ERR_LIMIT    (ERRL)
    ) dut (
        .CLKDIV     (CLKDIV),
        .asyncrst_n (asyncrst_n),
        .adc_en     (adc_en),
        .train_req  (train_req),
        .frm_data   (frm_data),
        .serdes_rst (serdes_rst),
        .serdes_ce  (serdes_ce),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .train_fail (train_fail),
        .slip_cnt   (slip_cnt),
        .retrain_cnt(retrain_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus countdown timers and plain counters.
    localparam int P_IDLE = 0, P_RST = 1, P_SETTLE = 2, P_CHECK = 3;
    localparam int P_SLIP = 4, P_VERIFY = 5, P_LOCKED = 6, P_FAIL = 7;

    int m_phase = P_IDLE, m_prev = P_IDLE, m_timer = 0, m_streak = 0, m_errs = 0;
    int e_slips = 0, e_retrains = 0;
    bit e_rst = 1'b1, e_ce = 1'b0, e_bitslip = 1'b0, e_aligned = 1'b0, e_fail = 1'b0;

    task automatic model_restart();
        m_phase = P_RST;
        m_timer = RSTC;
        e_slips = 0;
        e_fail  = 1'b0;
    endtask

    initial forever begin
        @(posedge CLKDIV or negedge asyncrst_n);
        if (!asyncrst_n) begin
            m_phase = P_IDLE; m_prev = P_IDLE; m_timer = 0; m_streak = 0; m_errs = 0;
            e_slips = 0; e_retrains = 0; e_fail = 1'b0;
        end else begin
            m_prev = m_phase;
            if (!adc_en) m_phase = P_IDLE;
            else if (train_req && m_phase != P_IDLE && m_phase != P_RST) model_restart();
            else begin
                case (m_phase)
                    P_IDLE: model_restart();
                    P_RST, P_SETTLE: begin
                        m_timer--;
                        if (m_timer == 0) begin
                            if (m_phase == P_RST) begin m_phase = P_SETTLE; m_timer = SETC; end
                            else m_phase = P_CHECK;
                        end
                    end
                    P_CHECK, P_VERIFY: begin
                        if (frm_data == PAT) begin
                            m_streak = (m_phase == P_CHECK) ? 1 : m_streak + 1;
                            if (m_streak >= LOCKC) begin m_phase = P_LOCKED; m_errs = 0; end
                            else m_phase = P_VERIFY;
                        end else begin
                            m_streak = 0;
                            if (e_slips < MAXS) begin e_slips++; m_phase = P_SLIP; end
                            else begin m_phase = P_FAIL; e_fail = 1'b1; end
                        end
                    end
                    P_SLIP: begin m_phase = P_SETTLE; m_timer = SETC; end
                    P_LOCKED: begin
                        m_errs = (frm_data == PAT) ? 0 : m_errs + 1;
                        if (m_errs == ERRL) begin
                            model_restart();
                            if (e_retrains < 255) e_retrains++;
                        end
                    end
                    default: ;
                endcase
            end
        end
        e_rst      = (m_phase == P_IDLE) || (m_phase == P_RST);
        e_ce       = !e_rst;
        e_bitslip  = (m_phase == P_SLIP);
        e_aligned  = (m_phase == P_LOCKED) && (m_prev == P_LOCKED);
    end

    // Deserializer stand-in: each expected bitslip rotates the word left by one.
    initial forever begin
        @(negedge CLKDIV);
        if (use_rot && e_bitslip) rot_word = {rot_word[6:0], rot_word[7]};
    end

    initial forever begin
        @(negedge CLKDIV);
        if (chk_on) begin
            check("serdes_rst",  int'(serdes_rst),  int'(e_rst));
            check("serdes_ce",   int'(serdes_ce),   int'(e_ce));
            check("bitslip",     int'(bitslip),     int'(e_bitslip));
            check("aligned",     int'(aligned),     int'(e_aligned));
            check("train_fail",  int'(train_fail),  int'(e_fail));
            check("slip_cnt",    int'(slip_cnt),    e_slips);
            check("retrain_cnt", int'(retrain_cnt), e_retrains);
        end
    end

    int cyc = 0, pulses = 0, last_pulse = -1000, min_gap = 1000;
    initial forever begin
        @(negedge CLKDIV);
        cyc++;
        if (bitslip) begin
            pulses++;
            if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
        end
    end

    task automatic clear_mon();
        pulses = 0; last_pulse = -1000; min_gap = 1000;
    endtask

    task automatic pulse_req();
        train_req = 1'b1;
        @(posedge CLKDIV);
        #1 train_req = 1'b0;
    endtask

    task automatic wait_aligned(input int lim, output int n);
        n = 0;
        do begin @(posedge CLKDIV); n++; @(negedge CLKDIV); end while (!aligned && n < lim);
    endtask

    task automatic wait_rst_low(input int lim, output int n);
        n = 0;
        do begin @(posedge CLKDIV); n++; @(negedge CLKDIV); end while (serdes_rst && n < lim);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_serdes_rst"},  int'(serdes_rst),  1);
        check({tag, "_serdes_ce"},   int'(serdes_ce),   0);
        check({tag, "_bitslip"},     int'(bitslip),     0);
        check({tag, "_aligned"},     int'(aligned),     0);
        check({tag, "_train_fail"},  int'(train_fail),  0);
        check({tag, "_slip_cnt"},    int'(slip_cnt),    0);
        check({tag, "_retrain_cnt"}, int'(retrain_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        repeat (2) @(posedge CLKDIV);
        #1 check_reset_values("reset");
        asyncrst_n = 1'b1;
        chk_on     = 1'b1;
        @(posedge CLKDIV);

        // 1: pattern present from the start; 1 edge into RST then 8 RST cycles.
        #1 clear_mon();
        adc_en = 1'b1;
        wait_rst_low(50, n);
        check("t1_rst_release_edges", n, 9);
        wait_aligned(100, n);
        check("t1_lock_latency", n, 20);
        check("t1_slip_cnt", int'(slip_cnt), 0);
        check("t1_no_bitslip", pulses, 0);

        // 2: word starts at 1E, needs three left rotations to reach F0.
        clear_mon();
        rot_word = 8'h1E;
        use_rot  = 1'b1;
        pulse_req();
        wait_aligned(300, n);
        check("t2_aligned", int'(aligned), 1);
        check("t2_slip_cnt", int'(slip_cnt), 3);
        check("t2_pulses", pulses, 3);
        check("t2_pulse_gap_ge4", int'(min_gap >= 4), 1);

        // 3: stuck word exhausts the slip budget.
        clear_mon();
        use_rot   = 1'b0;
        frm_fixed = 8'hAA;
        pulse_req();
        n = 0;
        while (!train_fail && n < 300) begin @(negedge CLKDIV); n++; end
        check("t3_train_fail", int'(train_fail), 1);
        check("t3_pulses", pulses, 8);
        check("t3_slip_cnt", int'(slip_cnt), 8);
        check("t3_aligned", int'(aligned), 0);
        repeat (10) @(negedge CLKDIV);
        check("t3_fail_held", int'(train_fail), 1);
        check("t3_no_extra_pulses", pulses, 8);
        pulse_req();
        @(negedge CLKDIV);
        check("t3_req_clears_fail", int'(train_fail), 0);
        check("t3_req_clears_slips", int'(slip_cnt), 0);
        check("t3_req_rst", int'(serdes_rst), 1);
        frm_fixed = PAT;
        wait_aligned(100, n);
        check("t3_relock", int'(aligned), 1);

        // 4: three errors recover, four force a retrain.
        frm_fixed = 8'h00;
        repeat (3) @(posedge CLKDIV);
        #1 frm_fixed = PAT;
        repeat (2) @(negedge CLKDIV);
        check("t4_three_err_aligned", int'(aligned), 1);
        check("t4_three_err_retrain", int'(retrain_cnt), 0);
        frm_fixed = 8'h00;
        repeat (4) @(posedge CLKDIV);
        #1 frm_fixed = PAT;
        @(negedge CLKDIV);
        check("t4_lost_aligned", int'(aligned), 0);
        check("t4_retrain_cnt", int'(retrain_cnt), 1);
        n = 0;
        while (serdes_rst && n < 50) begin n++; @(negedge CLKDIV); end
        check("t4_rst_hold_cycles", n, 8);
        wait_aligned(100, n);
        check("t4_relock", int'(aligned), 1);

        // 5: adc_en drop with a simultaneous train_req while in SLIP.
        clear_mon();
        frm_fixed = 8'hAA;
        pulse_req();
        n = 0;
        while (!bitslip && n < 100) begin @(negedge CLKDIV); n++; end
        check("t5_slip_seen", int'(bitslip), 1);
        adc_en    = 1'b0;
        train_req = 1'b1;
        @(posedge CLKDIV);
        #1 train_req = 1'b0;
        @(negedge CLKDIV);
        check("t5_bitslip_low", int'(bitslip), 0);
        check("t5_rst_high", int'(serdes_rst), 1);
        check("t5_ce_low", int'(serdes_ce), 0);
        check("t5_slip_cnt_held", int'(slip_cnt), 1);
        repeat (5) @(negedge CLKDIV);
        check("t5_idle_rst", int'(serdes_rst), 1);
        check("t5_slip_cnt_still", int'(slip_cnt), 1);
        check("t5_retrain_held", int'(retrain_cnt), 1);

        // 6: asynchronous reset in the middle of VERIFY.
        frm_fixed = PAT;
        adc_en    = 1'b1;
        wait_rst_low(50, n);
        repeat (8) @(posedge CLKDIV);
        #3 asyncrst_n = 1'b0;
        #1 check_reset_values("t6_async");
        repeat (2) @(negedge CLKDIV);
        #2 asyncrst_n = 1'b1;
        wait_aligned(100, n);
        check("t6_relock", int'(aligned), 1);
        check("t6_relock_edges", n, 29);
        check("t6_retrain_cnt", int'(retrain_cnt), 0);

        repeat (2) @(negedge CLKDIV);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
